// File: rtl/mem_bus_sched_pkg.sv
// Shared types and constants for the memory bus scheduler.
package mem_bus_sched_pkg;
    localparam int ADDR_WID   = 32;
    localparam int DATA_WID   = 32;
    localparam int IF_LEN_DEF = 4;

    // Upper address bits that select the UART window.
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;
    typedef enum logic {SRC_IF, SRC_LSB} src_e;
endpackage

// File: rtl/mem_bus_sched_if.sv
// Requester and memory-pin bundle seen by mem_bus_sched.
interface mem_bus_sched_if
    import mem_bus_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_WID,
    parameter int DATA_W = DATA_WID
) ();
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    logic              if_en;
    logic [ADDR_W-1:0] if_pc;
    logic              if_done;
    logic [DATA_W-1:0] if_data;

    logic              lsb_en;
    logic              lsb_rw;
    logic [ADDR_W-1:0] lsb_addr;
    logic [2:0]        lsb_len;
    logic [DATA_W-1:0] lsb_w_data;
    logic              lsb_done;
    logic [DATA_W-1:0] lsb_r_data;

    // Scheduler side: serves fetch/LSB requests and drives the memory pins.
    modport slave (
        input  mem_din, io_buffer_full,
        input  if_en, if_pc, lsb_en, lsb_rw, lsb_addr, lsb_len, lsb_w_data,
        output mem_dout, mem_a, mem_wr,
        output if_done, if_data, lsb_done, lsb_r_data
    );

    modport master (
        output mem_din, io_buffer_full,
        output if_en, if_pc, lsb_en, lsb_rw, lsb_addr, lsb_len, lsb_w_data,
        input  mem_dout, mem_a, mem_wr,
        input  if_done, if_data, lsb_done, lsb_r_data
    );
endinterface

// File: rtl/mem_byte_pack.sv
// Byte-lane helper: picks the outgoing write byte and merges/zero-extends read bytes.
module mem_byte_pack #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        wsel,
    output logic [7:0]        wbyte,
    input  logic [DATA_W-1:0] rbuf,
    input  logic [1:0]        rsel,
    input  logic [1:0]        lenm1,
    input  logic [7:0]        din,
    output logic [DATA_W-1:0] rword
);
    localparam int NUM_LANES = DATA_W / 8;

    assign wbyte = 8'(wdata >> {wsel, 3'b000});

    // Lanes beyond the transfer length read as zero so loads come back zero-extended.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign rword[8*i +: 8] = (2'(i) > lenm1) ? 8'h00 :
                                 (rsel == 2'(i)) ? din : rbuf[8*i +: 8];
    end
endmodule

// File: rtl/mem_bus_sched.sv
// Byte-wide memory port scheduler for IFetch and the LSB.
// Define MEM_SCHED_FAIR_EN for round-robin arbitration; default is fixed LSB > IF.
module mem_bus_sched
    import mem_bus_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_WID,
    parameter int DATA_W = DATA_WID,
    parameter int IF_LEN = IF_LEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            rollback,
    mem_bus_sched_if.slave  bus
);
    state_e            state;
    src_e              src;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rbuf;
    logic [DATA_W-1:0] rword;
    logic [1:0]        k;
    logic [1:0]        lenm1;
    logic [1:0]        wsel;
    logic [7:0]        wbyte;
    logic [2:0]        nxt_rd;
    logic              cap_vld;
    logic              stall;
    logic              gnt_if;
    logic              gnt_lsb;
`ifdef MEM_SCHED_FAIR_EN
    src_e              rr_ptr;
`endif

    always_comb begin
        gnt_if  = 1'b0;
        gnt_lsb = 1'b0;
        if (state == S_IDLE && !rollback) begin
`ifdef MEM_SCHED_FAIR_EN
            if (bus.if_en && bus.lsb_en) begin
                gnt_lsb = (rr_ptr == SRC_LSB);
                gnt_if  = (rr_ptr == SRC_IF);
            end else begin
                gnt_lsb = bus.lsb_en;
                gnt_if  = bus.if_en;
            end
`else
            gnt_lsb = bus.lsb_en;
            gnt_if  = bus.if_en && !bus.lsb_en;
`endif
        end
    end

    // k is the byte being captured; the address runs one byte ahead once data flows.
    assign nxt_rd = cap_vld ? ({1'b0, k} + 3'd2) : 3'd1;
    assign wsel   = k + 2'd1;
    assign stall  = (addr[17:16] == IO_ADDR_HI) && bus.io_buffer_full;
    assign bus.mem_wr = (state == S_WR) && rdy && !stall;

    mem_byte_pack #(.DATA_W(DATA_W)) u_pack (
        .wdata (wdata),
        .wsel  (wsel),
        .wbyte (wbyte),
        .rbuf  (rbuf),
        .rsel  (k),
        .lenm1 (lenm1),
        .din   (bus.mem_din),
        .rword (rword)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            src            <= SRC_IF;
            addr           <= '0;
            wdata          <= '0;
            rbuf           <= '0;
            k              <= '0;
            lenm1          <= '0;
            cap_vld        <= 1'b0;
            bus.mem_a      <= '0;
            bus.mem_dout   <= '0;
            bus.if_done    <= 1'b0;
            bus.lsb_done   <= 1'b0;
            bus.if_data    <= '0;
            bus.lsb_r_data <= '0;
`ifdef MEM_SCHED_FAIR_EN
            rr_ptr         <= SRC_IF;
`endif
        end else if (rdy) begin
            bus.if_done  <= 1'b0;
            bus.lsb_done <= 1'b0;
            case (state)
                S_IDLE: if (gnt_if || gnt_lsb) begin
                    k         <= '0;
                    cap_vld   <= 1'b0;
                    src       <= gnt_lsb ? SRC_LSB : SRC_IF;
                    addr      <= gnt_lsb ? bus.lsb_addr : bus.if_pc;
                    bus.mem_a <= gnt_lsb ? bus.lsb_addr : bus.if_pc;
                    lenm1     <= gnt_lsb ? 2'(bus.lsb_len - 3'd1) : 2'(IF_LEN - 1);
                    wdata     <= bus.lsb_w_data;
                    if (gnt_lsb && bus.lsb_rw) begin
                        bus.mem_dout <= bus.lsb_w_data[7:0];
                        state        <= S_WR;
                    end else begin
                        state        <= S_RD;
                    end
`ifdef MEM_SCHED_FAIR_EN
                    rr_ptr    <= gnt_lsb ? SRC_IF : SRC_LSB;
`endif
                end
                S_RD: if (rollback) begin
                    state   <= S_IDLE;
                    k       <= '0;
                    cap_vld <= 1'b0;
                end else begin
                    cap_vld <= 1'b1;
                    if (nxt_rd <= {1'b0, lenm1})
                        bus.mem_a <= addr + ADDR_W'(nxt_rd);
                    if (cap_vld) begin
                        rbuf <= rword;
                        if (k == lenm1) begin
                            state <= S_DONE;
                            if (src == SRC_IF) begin
                                bus.if_done <= 1'b1;
                                bus.if_data <= rword;
                            end else begin
                                bus.lsb_done   <= 1'b1;
                                bus.lsb_r_data <= rword;
                            end
                        end else begin
                            k <= k + 2'd1;
                        end
                    end
                end
                // Stores are committed, so rollback never interrupts them.
                S_WR: if (!stall) begin
                    if (k == lenm1) begin
                        state        <= S_DONE;
                        bus.lsb_done <= 1'b1;
                    end else begin
                        k            <= k + 2'd1;
                        bus.mem_a    <= addr + ADDR_W'({1'b0, k} + 3'd1);
                        bus.mem_dout <= wbyte;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
